multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control unit for a multicycle RV32 subset (lw, sw, R, I, beq, jal): one state
// register sequences each instruction, with memory waits held on mem_ready.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        Illegal,
    output logic [31:0] InstRet,
    output logic [3:0]  state_o
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic [2:0]  alu_dec;
    logic        retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // funct7 only selects sub for register-register ops (op[5]=1), never addi.
    always_comb begin
        case (funct3)
            3'b000:  alu_dec = (funct7 && op[5]) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB,
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BEQ));
    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        Illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_SW:   ImmSrc = 2'b01;
                    OP_BEQ:  ImmSrc = 2'b10;
                    OP_JAL:  ImmSrc = 2'b11;
                    default: ImmSrc = 2'b00;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                ImmSrc     = 2'b10;
                PCWrite    = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
            end
            S_TRAP:     Illegal = 1'b1;
            default:    Illegal = 1'b0;
        endcase
        // Reset blanks every control output immediately, not just from the next edge.
        if (rst) begin
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ImmSrc     = 2'b00;
            ALUControl = 3'b000;
            Illegal    = 1'b0;
        end
    end

    assign InstRet = instret_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: drivers push per-cycle expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;
    localparam int W = 54;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
        S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
        S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
        OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7 = 1'b0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] InstRet;
    logic [3:0]  state_o;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
        .InstRet(InstRet), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic [31:0]  exp_ret = '0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Vector layout: {InstRet, state, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite,
    // RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal}
    function automatic logic [W-1:0] obs_vec();
        return {InstRet, state_o, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal};
    endfunction

    function automatic logic [W-1:0] vec(input logic [3:0] st, input logic [5:0] en,
                                         input logic [1:0] asa, input logic [1:0] asb,
                                         input logic [1:0] rs, input logic [1:0] imm,
                                         input logic [2:0] alu, input logic ill);
        return {exp_ret, st, en, asa, asb, rs, imm, alu, ill};
    endfunction

    function automatic logic [W-1:0] v_fetch(input logic rdy);
        return vec(S_FETCH, {1'b1, 2'b00, rdy, rdy, 1'b0}, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0);
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) check(tag_q.pop_front(), obs_vec(), exp_q.pop_front());
    end

    task automatic step(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Inputs the current state must ignore get random values.
    task automatic noise();
        mem_ready = 1'($urandom_range(0, 1));
        Zero      = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input string tag);
        logic [W-1:0] v;
        rst = 1'b1;
        noise();
        @(negedge clk);
        v = obs_vec();
        v[W-1:18] = '0;
        check({tag, "_outs_zero"}, v, '0);
        @(posedge clk);
        #1;
        exp_ret = '0;
        step({tag, "_held"}, vec(S_FETCH, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        rst = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fst, input int mst);
        logic [1:0] imm;
        op = o;
        funct3 = f3;
        funct7 = f7;
        for (int i = 0; i < fst; i++) begin
            mem_ready = 1'b0;
            Zero = 1'($urandom_range(0, 1));
            step({name, "_fetch_wait"}, v_fetch(1'b0));
        end
        mem_ready = 1'b1;
        step({name, "_fetch"}, v_fetch(1'b1));
        case (o)
            OP_SW:   imm = 2'b01;
            OP_BEQ:  imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        noise();
        step({name, "_decode"}, vec(S_DECODE, 6'b0, 2'b01, 2'b01, 2'b00, imm, 3'b000, 1'b0));
        case (o)
            OP_LW, OP_SW: begin
                noise();
                step({name, "_memadr"}, vec(S_MEMADR, 6'b0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 1'b0));
                for (int i = 0; i <= mst; i++) begin
                    mem_ready = (i == mst);
                    Zero = 1'($urandom_range(0, 1));
                    if (o == OP_LW)
                        step({name, "_memread"}, vec(S_MEMREAD, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                    else
                        step({name, "_memwrite"}, vec(S_MEMWRITE, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                end
                if (o == OP_LW) begin
                    noise();
                    step({name, "_memwb"}, vec(S_MEMWB, 6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0));
                end
                exp_ret++;
            end
            OP_R, OP_I: begin
                noise();
                if (o == OP_R)
                    step({name, "_execr"}, vec(S_EXECR, 6'b0, 2'b10, 2'b00, 2'b00, 2'b00, exp_alu(o, f3, f7), 1'b0));
                else
                    step({name, "_execi"}, vec(S_EXECI, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00, exp_alu(o, f3, f7), 1'b0));
                noise();
                step({name, "_aluwb"}, vec(S_ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                exp_ret++;
            end
            OP_BEQ: begin
                mem_ready = 1'($urandom_range(0, 1));
                Zero = z;
                step({name, "_beq"}, vec(S_BEQ, {4'b0000, z, 1'b0}, 2'b10, 2'b00, 2'b00, 2'b10, 3'b001, 1'b0));
                exp_ret++;
            end
            OP_JAL: begin
                noise();
                step({name, "_jal"}, vec(S_JAL, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b11, 3'b000, 1'b0));
                noise();
                step({name, "_aluwb"}, vec(S_ALUWB, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                exp_ret++;
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    noise();
                    step({name, "_trap"}, vec(S_TRAP, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
                end
            end
        endcase
    endtask

    logic [6:0] legal_ops[6];

    initial begin
        legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        do_reset("por");

        run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("add", OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("addi_f7", OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("slt", OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("or", OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
        run_instr("andi", OP_I, 3'b111, 1'b1, 1'b0, 0, 0);
        run_instr("r_f3_001", OP_R, 3'b001, 1'b1, 1'b0, 0, 0);
        run_instr("beq_taken", OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_not", OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sw_stall", OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr("lw_stall", OP_LW, 3'b010, 1'b0, 1'b0, 2, 2);

        for (int k = 0; k < 24; k++) begin
            run_instr("rnd", legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Reset while a store is waiting on memory.
        op = OP_SW;
        mem_ready = 1'b1;
        step("mid_fetch", v_fetch(1'b1));
        noise();
        step("mid_decode", vec(S_DECODE, 6'b0, 2'b01, 2'b01, 2'b00, 2'b01, 3'b000, 1'b0));
        noise();
        step("mid_memadr", vec(S_MEMADR, 6'b0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 1'b0));
        mem_ready = 1'b0;
        step("mid_wait", vec(S_MEMWRITE, 6'b011000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        do_reset("midwait_rst");
        run_instr("after_mid", OP_I, 3'b000, 1'b0, 1'b0, 0, 0);

        // Counter wrap: hold the counter at all-ones across one edge, then retire.
        force dut.instret_q = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
        op = OP_R;
        mem_ready = 1'b0;
        step("wrap_hold", v_fetch(1'b0));
        release dut.instret_q;
        run_instr("wrap", OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
        mem_ready = 1'b0;
        step("wrap_zero", v_fetch(1'b0));

        run_instr("illegal", OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
        do_reset("trap_rst");
        run_instr("after_trap", OP_LW, 3'b010, 1'b0, 1'b0, 0, 1);
        mem_ready = 1'b0;
        step("final_fetch", v_fetch(1'b0));

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
